// File: rtl/dmem_unit.sv
// Multi-cycle data memory: IDLE/ACCESS/DONE handshake with the datapath via stall.
// Optional sub-word (byte/half) stores and sign/zero-extending loads under `DMEM_SUBWORD_EN.
module dmem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          rd_q;
`ifdef DMEM_SUBWORD_EN
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          uns_q;
`endif

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word;
  logic [31:0] load_val;
  logic [31:0] wlane;
  logic [3:0]  be;
  logic        req;
  logic        mis_req;
  logic        mem_we;

  // High address bits alias onto the array by design.
  logic unused_bits;
`ifdef DMEM_SUBWORD_EN
  assign unused_bits = &{1'b0, addr[31:AW+2]};
`else
  assign unused_bits = &{1'b0, addr[31:AW+2], size, ld_unsigned};
`endif

  assign req    = memread | memwrite;
  assign stall  = ((state == IDLE) && req) || (state == ACCESS);
  assign mem_we = (state == ACCESS) && wr_q;
  assign word   = mem[idx_q];

  always_comb begin
`ifdef DMEM_SUBWORD_EN
    case (size)
      2'b00:   mis_req = 1'b0;
      2'b01:   mis_req = addr[0];
      default: mis_req = |addr[1:0];
    endcase
`else
    mis_req = |addr[1:0];
`endif
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be       = 4'hf;
    wlane    = wdata_q;
    load_val = word;
`ifdef DMEM_SUBWORD_EN
    case (size_q)
      2'b00: begin
        logic [7:0] b;
        be       = 4'b0001 << lane_q;
        wlane    = {4{wdata_q[7:0]}};
        b        = word[{lane_q, 3'b000} +: 8];
        load_val = uns_q ? {24'b0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        be       = lane_q[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_q[15:0]}};
        h        = lane_q[1] ? word[31:16] : word[15:0];
        load_val = uns_q ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: ;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      readdata   <= '0;
      misaligned <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
`ifdef DMEM_SUBWORD_EN
      lane_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= addr[AW+1:2];
            wdata_q <= writedata;
            wr_q    <= memwrite;
            rd_q    <= memread;
`ifdef DMEM_SUBWORD_EN
            lane_q  <= addr[1:0];
            size_q  <= size;
            uns_q   <= ld_unsigned;
`endif
            if (mis_req) begin
              state      <= DONE;
              misaligned <= 1'b1;
              readdata   <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state <= DONE;
          // A combined read+write is a store; the load result is forced to zero.
          if (wr_q && rd_q) readdata <= '0;
          else if (rd_q)    readdata <= load_val;
        end
        DONE: begin
          state      <= IDLE;
          misaligned <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst and start undefined.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: timing, faults, reset abort, aliasing, sub-word access.
module tb_dmem_unit;

  localparam int DEPTH_WORDS = 256;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .size(size), .ld_unsigned(ld_unsigned),
    .readdata(readdata), .stall(stall), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request starting just after a rising edge; returns stall-cycle count and DONE-cycle outputs.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns,
                        output int stalls, output logic [31:0] rdata, output logic mis);
    memread = rd; memwrite = wr; addr = a; writedata = d; size = sz; ld_unsigned = uns;
    stalls = 0;
    #1;
    while (stall && stalls < 8) begin
      stalls++;
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0;
      #1;
    end
    rdata = readdata;
    mis   = misaligned;
    @(posedge clk); #1;
  endtask

  int          st;
  logic [31:0] rdv;
  logic        mis;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    size = 2'b10; ld_unsigned = 1'b0;
    #12;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_mis", {31'b0, misaligned}, 32'd0);
    check("reset_rdata", readdata, 32'h0);
    #8 rst = 1'b1;
    @(posedge clk); #1;

    // Aligned word store then load.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, st, rdv, mis);
    check("store_stalls", st, 32'd2);
    check("store_mis", {31'b0, mis}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("load_stalls", st, 32'd2);
    check("load_data", rdv, 32'hDEADBEEF);

    // Misaligned word load.
    access(1'b1, 1'b0, 32'h13, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("mis_stalls", st, 32'd1);
    check("mis_flag", {31'b0, mis}, 32'd1);
    check("mis_rdata", rdv, 32'h0);
    check("mis_clears", {31'b0, misaligned}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("after_mis_data", rdv, 32'hDEADBEEF);

    // Reset pulsed during ACCESS of a store aborts it.
    memwrite = 1'b1; addr = 32'h10; writedata = 32'hCAFEF00D; size = 2'b10;
    #1;
    check("rst_abort_idle_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    memwrite = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_abort_stall", {31'b0, stall}, 32'd0);
    check("rst_abort_rdata", readdata, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_idle", {31'b0, stall}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("rst_abort_data", rdv, 32'hDEADBEEF);

    // Aliasing: high address bits ignored.
    access(1'b0, 1'b1, 32'h10 + 4 * DEPTH_WORDS, 32'hA5A55A5A, 2'b10, 1'b0, st, rdv, mis);
    check("alias_mis", {31'b0, mis}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("alias_data", rdv, 32'hA5A55A5A);

    // Read and write together behave as a store with zero read data.
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, st, rdv, mis);
    check("both_stalls", st, 32'd2);
    check("both_rdata", rdv, 32'h0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("both_written", rdv, 32'h12345678);

    // Misaligned store must not write.
    access(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, st, rdv, mis);
    check("mis_store_flag", {31'b0, mis}, 32'd1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("mis_store_nowrite", rdv, 32'h12345678);

    // Idle cycle: no request, no stall.
    #1;
    check("idle_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

`ifdef DMEM_SUBWORD_EN
    access(1'b0, 1'b1, 32'h24, 32'h00000080, 2'b10, 1'b0, st, rdv, mis);
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b00, 1'b0, st, rdv, mis);
    check("lb_signed", rdv, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b00, 1'b1, st, rdv, mis);
    check("lb_unsigned", rdv, 32'h00000080);
    access(1'b0, 1'b1, 32'h27, 32'hAAAAAA11, 2'b00, 1'b0, st, rdv, mis);
    check("sb_mis", {31'b0, mis}, 32'd0);
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b10, 1'b0, st, rdv, mis);
    check("sb_lane3", rdv, 32'h11000080);
    access(1'b1, 1'b0, 32'h26, 32'h0, 2'b01, 1'b0, st, rdv, mis);
    check("lh_upper", rdv, 32'h00001100);
    access(1'b1, 1'b0, 32'h25, 32'h0, 2'b01, 1'b0, st, rdv, mis);
    check("lh_mis_flag", {31'b0, mis}, 32'd1);
    check("lh_mis_stalls", st, 32'd1);
`else
    access(1'b0, 1'b1, 32'h24, 32'hCAFE0080, 2'b00, 1'b0, st, rdv, mis);
    check("word_only_store_mis", {31'b0, mis}, 32'd0);
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b00, 1'b0, st, rdv, mis);
    check("word_only_load", rdv, 32'hCAFE0080);
    access(1'b1, 1'b0, 32'h25, 32'h0, 2'b00, 1'b0, st, rdv, mis);
    check("word_only_mis_flag", {31'b0, mis}, 32'd1);
    check("word_only_mis_stalls", st, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter AW, default log2(DEPTH_WORDS), giving the word-index width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports in this order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- memread  input  1  load request
- memwrite  input  1  store request
- addr  input  32  byte address (datapath ALU result)
- writedata  input  32  store data
- size  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
- ld_unsigned  input  1  zero-extend sub-word loads
- readdata  output  32  load result
- stall  output  1  datapath must hold PC and state
- misaligned  output  1  one-cycle access-fault flag

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-006 SHALL treat memread|memwrite in IDLE as a request; in ACCESS and DONE, new requests are ignored.
REQ-007 In IDLE with a request, stall SHALL be 1 combinationally in the same cycle, and addr, writedata, size, ld_unsigned and the op SHALL be latched.
REQ-008 IDLE + aligned request -> ACCESS; ACCESS -> DONE; DONE -> IDLE unconditionally.
REQ-009 stall SHALL be 1 in ACCESS and 0 in DONE, so an aligned access costs 2 stall cycles and completes in the DONE cycle.
REQ-010 Stores SHALL update the array on the clock edge leaving ACCESS.
REQ-011 Loads SHALL read the array at the latched address and register the result into readdata on the edge leaving ACCESS.
REQ-012 readdata SHALL hold its value until the next completed load or fault.
REQ-013 If memread and memwrite are both set, the request SHALL be treated as a store; readdata SHALL be 0 in DONE.
REQ-014 Word index SHALL be addr[AW+1:2]; higher address bits are ignored (aliasing, no fault).
REQ-015 Misaligned means a word access with addr[1:0]!=0 or a half access with addr[0]=1.
REQ-016 On a misaligned request: IDLE -> DONE directly (1 stall cycle), no array write, readdata=0, misaligned=1 for exactly the DONE cycle.
REQ-017 Non-request cycles SHALL leave stall=0 and the array untouched; no latency is added.
REQ-018 Array contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE, stall=0, misaligned=0, readdata=0 and clear the latched request.
REQ-020 Reset asserted in ACCESS SHALL discard the pending store; the array SHALL NOT be written.
REQ-021 After rst returns to 1, the first rising edge SHALL behave as IDLE.

Configuration
REQ-022 Macro DMEM_SUBWORD_EN SHALL select sub-word access support.
REQ-023 With DMEM_SUBWORD_EN defined:
- stores SHALL write only the byte or half lanes selected by size and addr[1:0], taking data from writedata low bits;
- loads SHALL extract the addressed byte or half, sign-extended, or zero-extended when ld_unsigned=1.
REQ-024 Without DMEM_SUBWORD_EN:
- size and ld_unsigned SHALL be ignored and every access is a full word;
- misalignment SHALL be any addr[1:0]!=0.

Verification
REQ-025 SHALL cover: reset, then store word addr=0x10 data=0xDEADBEEF -> stall=1 for 2 cycles, 0 in DONE; later load addr=0x10 -> readdata=0xDEADBEEF in DONE.
REQ-026 SHALL cover: load word addr=0x13 -> stall=1 for 1 cycle, misaligned=1 in DONE, readdata=0, word at 0x10 unchanged.
REQ-027 SHALL cover: store to addr=0x10 with reset pulsed low during ACCESS -> state IDLE, stall=0; reading 0x10 afterwards returns the prior value.
REQ-028 SHALL cover: addr=0x10 and addr=0x10+4*DEPTH_WORDS -> both reach the same word (alias).
REQ-029 SHALL cover: memread=memwrite=1 at addr=0x20 data=0x12345678 -> word written, readdata=0 in DONE.
REQ-030 SHALL cover, with DMEM_SUBWORD_EN defined: word 0x80 stored at 0x24, then signed byte load at 0x24 -> readdata=0xFFFFFF80; unsigned byte load -> 0x00000080.
